// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and latency codes for the per-register hazard scoreboard.
// A countdown of all ones marks a variable-latency producer that waits for writeback.
package scoreboard_pkg;

    localparam int SB_LAT_W = 3;

    localparam logic [SB_LAT_W-1:0] LAT_VAR      = '1;
    localparam logic [SB_LAT_W-1:0] LAT_ALU      = SB_LAT_W'(0);
    localparam logic [SB_LAT_W-1:0] LAT_LOAD_HIT = SB_LAT_W'(1);
    localparam logic [SB_LAT_W-1:0] LAT_MUL      = SB_LAT_W'(2);
    localparam logic [SB_LAT_W-1:0] LAT_DIV      = LAT_VAR;

    typedef struct packed {
        logic                pend;
        logic                vlat;
        logic [SB_LAT_W-1:0] cnt;
    } sb_entry_t;

    function automatic logic sb_hazard(input sb_entry_t e);
        return e.pend && (e.vlat || (e.cnt != '0));
    endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard entry: resolves issue, kill-undo, writeback and countdown
// for a single architectural register, in that priority order.
module sb_entry
    import scoreboard_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      set,
    input  sb_entry_t set_val,
    input  logic      undo,
    input  sb_entry_t undo_val,
    input  logic      wb,
    output sb_entry_t ent
);

    sb_entry_t nxt;

    always_comb begin
        nxt = ent;
        if (set) begin
            nxt = set_val;
        end else if (undo) begin
            nxt = undo_val;
        end else if (wb && ent.vlat) begin
            nxt.pend = 1'b0;
            nxt.vlat = 1'b0;
        end else if (!ent.vlat && (ent.cnt != '0)) begin
            // pend drops together with the last decrement
            nxt.cnt  = ent.cnt - SB_LAT_W'(1);
            nxt.pend = (ent.cnt != SB_LAT_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent <= '0;
        end else begin
            ent <= nxt;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register pending state, one-deep kill undo,
// and a combinational stall for sources (and optionally the destination).
module hazard_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int IDX_W     = $clog2(NUM_REGS),
    parameter int LAT_W     = SB_LAT_W,
    parameter int WAW_CHECK = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_valid,
    input  logic [IDX_W-1:0]    dec_rs1,
    input  logic [IDX_W-1:0]    dec_rs2,
    input  logic                dec_rs1_used,
    input  logic                dec_rs2_used,
    input  logic [IDX_W-1:0]    dec_rd,
    input  logic                dec_rd_used,
    input  logic [LAT_W-1:0]    dec_lat,
    input  logic                wb_done,
    input  logic [IDX_W-1:0]    wb_rd,
    input  logic                kill,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy
);

    sb_entry_t           ent [NUM_REGS];
    logic [NUM_REGS-1:0] haz;
    logic                src1_hit, src2_hit, rd_hit;
    logic                issue, wr;
    sb_entry_t           new_ent;

    logic                undo_vld;
    logic [IDX_W-1:0]    undo_idx;
    sb_entry_t           undo_ent;
    logic                undo_fire;

    assign ent[0] = '0;

    always_comb begin
        haz  = '0;
        busy = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            haz[i]  = sb_hazard(ent[i]);
            busy[i] = ent[i].pend;
        end
    end

    // Register 0 never holds a hazard, so the index != 0 test is implicit in haz[0] = 0.
    assign src1_hit = dec_rs1_used && (dec_rs1 != '0) && haz[dec_rs1];
    assign src2_hit = dec_rs2_used && (dec_rs2 != '0) && haz[dec_rs2];
    assign rd_hit   = (WAW_CHECK != 0) && dec_rd_used && (dec_rd != '0) && haz[dec_rd];
    assign stall    = dec_valid && (src1_hit || src2_hit || rd_hit);

    assign issue = dec_valid && !stall && !kill;
    assign wr    = issue && dec_rd_used && (dec_rd != '0);

    always_comb begin
        new_ent      = '0;
        new_ent.pend = (dec_lat != '0);
        new_ent.vlat = (dec_lat == LAT_VAR);
        new_ent.cnt  = ((dec_lat == LAT_VAR) || (dec_lat == '0)) ? '0 : dec_lat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            undo_vld <= 1'b0;
        end else begin
            undo_vld <= wr;
        end
    end

    // Snapshot of the overwritten entry so a redirect next cycle can put it back.
    always_ff @(posedge clk) begin
        if (wr) begin
            undo_idx <= dec_rd;
            undo_ent <= ent[dec_rd];
        end
    end

    assign undo_fire = kill && undo_vld;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
        sb_entry u_entry (
            .clk      (clk),
            .rst      (rst),
            .set      (wr && (dec_rd == IDX_W'(i))),
            .set_val  (new_ent),
            .undo     (undo_fire && (undo_idx == IDX_W'(i))),
            .undo_val (undo_ent),
            .wb       (wb_done && (wb_rd == IDX_W'(i))),
            .ent      (ent[i])
        );
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; a second instance runs with WAW checking off.
module tb_hazard_scoreboard;
    import scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_rs1_used, dec_rs2_used, dec_rd_used;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd;
    logic [2:0]  dec_lat;
    logic        wb_done, kill;
    logic        stall, stall_nw;
    logic [31:0] busy, busy_nw;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.WAW_CHECK(1)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
        .dec_rd(dec_rd), .dec_rd_used(dec_rd_used), .dec_lat(dec_lat),
        .wb_done(wb_done), .wb_rd(wb_rd), .kill(kill),
        .stall(stall), .busy(busy)
    );

    hazard_scoreboard #(.WAW_CHECK(0)) dut_nw (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
        .dec_rd(dec_rd), .dec_rd_used(dec_rd_used), .dec_lat(dec_lat),
        .wb_done(wb_done), .wb_rd(wb_rd), .kill(kill),
        .stall(stall_nw), .busy(busy_nw)
    );

    task automatic clr();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_used = 0; dec_rs2_used = 0;
        dec_rd = 0; dec_rd_used = 0; dec_lat = 0; wb_done = 0; wb_rd = 0; kill = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr();
        rst = 1;
        tick();
        tick();
        rst = 0;
        tick();
    endtask

    // Present a producer for one cycle, then return to idle.
    task automatic produce(input logic [4:0] rd, input logic [2:0] lat);
        clr();
        dec_valid = 1; dec_rd = rd; dec_rd_used = 1; dec_lat = lat;
        tick();
        clr();
    endtask

    task automatic consume(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
        clr();
        dec_valid = 1; dec_rs1 = rs1; dec_rs1_used = u1; dec_rs2 = rs2; dec_rs2_used = u2;
    endtask

    // Count consecutive stalled cycles of the WAW-checking instance, bounded.
    task automatic count_stall(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!stall) break;
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        clr();
        rst = 1;
        #1;
        n_tests++;
        if (busy !== 32'h0 || busy_nw !== 32'h0) begin
            n_fail++; $display("FAIL reset_busy: got %h/%h expected 0", busy, busy_nw);
        end
        rst = 0;
        do_reset();
        consume(5'd1, 1, 5'd2, 1);
        #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b expected 0", stall);
        end
        clr();
    endtask

    task automatic test_load_use();
        int n;
        do_reset();
        produce(5'd5, LAT_LOAD_HIT);
        consume(5'd5, 1, 5'd0, 0);
        #1;
        n_tests++;
        if (busy !== 32'h0000_0020) begin
            n_fail++; $display("FAIL load_use_busy: got %h expected 00000020", busy);
        end
        count_stall(n);
        n_tests++;
        if (n !== 1) begin
            n_fail++; $display("FAIL load_use_stall_cycles: got %0d expected 1", n);
        end
        n_tests++;
        if (busy !== 32'h0) begin
            n_fail++; $display("FAIL load_use_busy_clear: got %h expected 0", busy);
        end
        tick();
        clr();
    endtask

    task automatic test_mul();
        int n;
        do_reset();
        produce(5'd7, LAT_MUL);
        consume(5'd0, 0, 5'd7, 1);
        count_stall(n);
        n_tests++;
        if (n !== 2) begin
            n_fail++; $display("FAIL mul_stall_cycles: got %0d expected 2", n);
        end
        tick();
        produce(5'd7, LAT_MUL);
        consume(5'd0, 0, 5'd7, 0);
        count_stall(n);
        n_tests++;
        if (n !== 0) begin
            n_fail++; $display("FAIL mul_unused_src: got %0d expected 0", n);
        end
        tick();
        clr();
    endtask

    task automatic test_var_load();
        int n;
        do_reset();
        produce(5'd9, LAT_VAR);
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            consume(5'd9, 1, 5'd0, 0);
            if (c == 10) begin
                wb_done = 1; wb_rd = 5'd9;
            end
            #1;
            if (stall) n++;
            tick();
        end
        consume(5'd9, 1, 5'd0, 0);
        #1;
        n_tests++;
        if (n !== 10) begin
            n_fail++; $display("FAIL var_stall_cycles: got %0d expected 10", n);
        end
        n_tests++;
        if (stall !== 1'b0 || busy[9] !== 1'b0) begin
            n_fail++; $display("FAIL var_release: got stall=%b busy9=%b expected 0/0", stall, busy[9]);
        end
        tick();
        // writeback aimed at the register being issued does not cancel the new entry
        clr();
        dec_valid = 1; dec_rd = 5'd9; dec_rd_used = 1; dec_lat = LAT_VAR;
        wb_done = 1; wb_rd = 5'd9;
        tick();
        clr();
        #1;
        n_tests++;
        if (busy[9] !== 1'b1) begin
            n_fail++; $display("FAIL var_wb_same_cycle: got %b expected 1", busy[9]);
        end
    endtask

    task automatic test_waw();
        int n;
        do_reset();
        produce(5'd3, LAT_VAR);
        clr();
        dec_valid = 1; dec_rd = 5'd3; dec_rd_used = 1; dec_lat = LAT_LOAD_HIT;
        #1;
        n_tests++;
        if (stall !== 1'b1 || stall_nw !== 1'b0) begin
            n_fail++; $display("FAIL waw_stall: got %b/%b expected 1/0", stall, stall_nw);
        end
        n = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                wb_done = 1; wb_rd = 5'd3;
            end
            #1;
            if (stall) n++;
            tick();
        end
        wb_done = 0;
        #1;
        n_tests++;
        if (n !== 4 || stall !== 1'b0) begin
            n_fail++; $display("FAIL waw_release: got cycles=%0d stall=%b expected 4/0", n, stall);
        end
        tick();
        clr();
        #1;
        n_tests++;
        if (busy[3] !== 1'b1) begin
            n_fail++; $display("FAIL waw_reissue_busy: got %b expected 1", busy[3]);
        end
    endtask

    task automatic test_x0();
        do_reset();
        produce(5'd0, LAT_LOAD_HIT);
        produce(5'd0, LAT_VAR);
        consume(5'd0, 1, 5'd0, 1);
        dec_rd_used = 1;
        #1;
        n_tests++;
        if (stall !== 1'b0 || busy !== 32'h0) begin
            n_fail++; $display("FAIL x0: got stall=%b busy=%h expected 0/0", stall, busy);
        end
        tick();
        clr();
    endtask

    task automatic test_lat0_overwrite();
        do_reset();
        produce(5'd8, LAT_MUL);
        clr();
        dec_valid = 1; dec_rd = 5'd8; dec_rd_used = 1; dec_lat = LAT_ALU;
        #1;
        n_tests++;
        if (stall !== 1'b1 || stall_nw !== 1'b0) begin
            n_fail++; $display("FAIL lat0_stall: got %b/%b expected 1/0", stall, stall_nw);
        end
        tick();
        clr();
        #1;
        n_tests++;
        if (busy_nw[8] !== 1'b0 || busy[8] !== 1'b1) begin
            n_fail++; $display("FAIL lat0_overwrite: got nw=%b waw=%b expected 0/1", busy_nw[8], busy[8]);
        end
    endtask

    task automatic test_kill();
        do_reset();
        produce(5'd4, LAT_MUL);
        kill = 1;
        #1;
        n_tests++;
        if (busy[4] !== 1'b1) begin
            n_fail++; $display("FAIL kill_pre_busy: got %b expected 1", busy[4]);
        end
        tick();
        consume(5'd4, 1, 5'd0, 0);
        #1;
        n_tests++;
        if (busy[4] !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL kill_restore_empty: got busy4=%b stall=%b expected 0/0", busy[4], stall);
        end
        tick();
        // prior variable producer on r4 must survive a squashed overwrite
        do_reset();
        produce(5'd4, LAT_VAR);
        clr();
        dec_valid = 1; dec_rd = 5'd4; dec_rd_used = 1; dec_lat = LAT_MUL;
        tick();
        clr();
        kill = 1;
        tick();
        consume(5'd4, 1, 5'd0, 0);
        tick();
        tick();
        tick();
        #1;
        n_tests++;
        if (stall_nw !== 1'b1 || busy_nw[4] !== 1'b1) begin
            n_fail++; $display("FAIL kill_restore_var: got stall=%b busy4=%b expected 1/1", stall_nw, busy_nw[4]);
        end
        wb_done = 1; wb_rd = 5'd4;
        tick();
        wb_done = 0;
        #1;
        n_tests++;
        if (stall_nw !== 1'b0) begin
            n_fail++; $display("FAIL kill_var_wb: got %b expected 0", stall_nw);
        end
        tick();
        clr();
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        produce(5'd10, LAT_LOAD_HIT);
        produce(5'd11, LAT_MUL);
        consume(5'd10, 1, 5'd11, 1);
        count_stall(n);
        n_tests++;
        if (n !== 2) begin
            n_fail++; $display("FAIL b2b_stall_cycles: got %0d expected 2", n);
        end
        tick();
        clr();
    endtask

    task automatic test_async_reset();
        do_reset();
        produce(5'd6, 3'd3);
        tick();
        consume(5'd6, 1, 5'd0, 0);
        #1;
        n_tests++;
        if (stall !== 1'b1 || busy !== 32'h0000_0040) begin
            n_fail++; $display("FAIL areset_pre: got stall=%b busy=%h expected 1/00000040", stall, busy);
        end
        #2 rst = 1;
        #1;
        n_tests++;
        if (stall !== 1'b0 || busy !== 32'h0) begin
            n_fail++; $display("FAIL areset_now: got stall=%b busy=%h expected 0/0", stall, busy);
        end
        #1 rst = 0;
        tick();
        #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL areset_after: got %b expected 0", stall);
        end
        tick();
        clr();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 0;
        clr();
        test_reset();
        test_load_use();
        test_mul();
        test_var_load();
        test_waw();
        test_x0();
        test_lat0_overwrite();
        test_kill();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Per-register hazard scoreboard that replaces the fixed load-use detector between decode and execute. Tracks every in-flight destination register with a latency countdown or a wait-for-writeback flag. Raises a decode stall whenever a decoding instruction's sources, or optionally its destination, hit an unresolved producer. Supports fixed-latency units (load-use, multiplier) and variable-latency units (cache-miss loads, divider) in one structure.

## Interface
Parameters:
- NUM_REGS, 32: architectural registers; register 0 is hardwired zero.
- IDX_W, $clog2(NUM_REGS): register index width.
- LAT_W, 3: countdown width; all-ones code LAT_VAR means variable latency.
- WAW_CHECK, 1: when 1, also stall on a destination that matches a pending entry.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- dec_valid  in  1  decode slot holds a real instruction.
- dec_rs1, dec_rs2  in  IDX_W  source indices.
- dec_rs1_used, dec_rs2_used  in  1  source actually read (opcode-decoded).
- dec_rd  in  IDX_W  destination index.
- dec_rd_used  in  1  instruction writes rd.
- dec_lat  in  LAT_W  stall cycles a back-to-back consumer needs; 0 means fully forwardable; LAT_VAR means wait for wb_done.
- wb_done  in  1  a variable-latency result is written back or forwardable this cycle.
- wb_rd  in  IDX_W  destination of that result.
- kill  in  1  squash the instruction issued last cycle (branch redirect).
- stall  out  1  hold decode and bubble execute.
- busy  out  NUM_REGS  per-register pending flag, for debug and trace.

## Operation
- Per-entry state: pend (1 b), var (1 b), cnt (LAT_W). An entry is hazardous when pend && (var || cnt != 0).
- stall = dec_valid && (src1 hit || src2 hit || (WAW_CHECK && rd hit)). A source hit requires used && idx != 0 && the entry is hazardous.
- issue = dec_valid && !stall && !kill.
- On issue with dec_rd_used && dec_rd != 0 && dec_lat != 0, the rd entry is set:
  - pend=1;
  - var=(dec_lat==LAT_VAR);
  - cnt=(var ? 0 : dec_lat).
- Every cycle, each non-var entry with cnt != 0 decrements; when it reaches 0, pend clears in the same update.
- wb_done clears pend and var of wb_rd. wb_done on a non-var entry is ignored.
- kill restores the entry written by last cycle's issue to its prior state. A one-deep undo register holds the index, the prior entry value, and a valid bit.
- Simultaneous events on the same index resolve in this priority: rst > issue (new producer wins) > kill undo > wb_done > decrement.
- Register 0 is never written, never pending, and never hits.
- dec_lat == 0 creates no entry; an existing entry on that rd is overwritten to not-pending when WAW_CHECK=0.

## Timing
- Reset: all pend/var/cnt = 0, undo valid = 0, stall = 0, busy = 0.
- stall is combinational from registered state and the current dec_* inputs; no cycle of latency.
- Entry update is registered: the consumer decoding the cycle after the producer issues sees cnt=dec_lat.
- A fixed-latency producer with dec_lat=N stalls an adjacent consumer exactly N cycles.
- A variable producer stalls its consumer until the cycle after wb_done. wb_done combinationally unblocks nothing.
- wb_done in the issue cycle of the same rd has no effect on the new entry.
- Reset asserted mid-countdown clears all entries asynchronously. The first cycle after deassertion shows stall=0.

## Structure
- Shared package scoreboard_pkg:
  - sb_entry_t struct {pend, var, cnt};
  - LAT_VAR constant;
  - latency constants LAT_ALU=0, LAT_LOAD_HIT=1, LAT_MUL=2, LAT_DIV=LAT_VAR.
- One natural sub-module, sb_entry: a single entry's next-state logic with priority resolution. It is instantiated NUM_REGS-1 times via generate; the top level holds hit muxing, the undo register, and stall.

## Test plan
- Load-use: issue rd=5 with lat=1, then decode rs1=5 → stall exactly 1 cycle, busy[5] high 1 cycle.
- Multiply chain: rd=7 with lat=2, then consumer rs2=7, rs2_used=1 → 2 stall cycles. The same consumer with rs2_used=0 → 0 stall.
- Variable load: rd=9 with LAT_VAR; hold consumer rs1=9 for 10 cycles, pulse wb_done with wb_rd=9 in cycle 10 → stall through cycle 10, clear in cycle 11.
- WAW and x0:
  - WAW_CHECK=1, pending var rd=3, decode rd=3 → stall until wb_done.
  - Producer rd=0 with lat=1 → no entry, consumer rs1=0 never stalls.
- Kill: issue rd=4 with lat=2, assert kill next cycle → busy[4] returns to its prior value (0) and a consumer on r4 sees no stall. Repeat with prior pending var r4 → var restored.
- Async reset: mid-countdown on rd=6 with cnt=2, pulse rst between edges → busy=0 and stall=0 immediately.
